// File: rtl/cache_mem_responder.sv
// cache_mem_responder: memory-side responder for the data cache miss path.
// Accepts one full-line read or write request at a time. The backing word array
// has a fixed access latency. Reads return WORDS beats. Writes consume WORDS beats
// and then pulse wr_done.
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   req_valid/req_ready          line request handshake
//   req_write, req_addr          1 = writeback, 0 = refill; byte address in line
//   rvalid/rready, rdata, rlast  read beat channel
//   wvalid/wready, wdata         write beat channel
//   wr_done                      one-cycle writeback completion pulse
//   busy                         request in progress
module cache_mem_responder #(
  parameter int unsigned BLOCK_SIZE = 32,
  parameter int unsigned MEM_DEPTH  = 1024,
  parameter int unsigned LATENCY    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        rlast,
  input  logic        rready,
  input  logic        wvalid,
  input  logic [31:0] wdata,
  output logic        wready,
  output logic        wr_done,
  output logic        busy
);

  localparam int unsigned WORDS  = BLOCK_SIZE / 4;
  localparam int unsigned BEAT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned ADDR_W = $clog2(MEM_DEPTH);
  localparam int unsigned LINE_W = ADDR_W - BEAT_W;
  localparam int unsigned CNT_W  = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WAIT   = 3'd1;
  localparam logic [2:0] RBURST = 3'd2;
  localparam logic [2:0] WBURST = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [31:0]       mem [MEM_DEPTH];

  logic [2:0]        state, state_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              write_q, write_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              rvalid_d, rlast_d, wready_d, wr_done_d, busy_d;
  logic [31:0]       rdata_d;

  // Address bits below the line and above the array are intentionally dropped
  // (line alignment and modulo-depth wrap; MEM_DEPTH is a power of two).
  logic unused_addr;
  assign unused_addr = ^{req_addr[31:ADDR_W+2], req_addr[BEAT_W+1:0]};

  // Ready is held low by reset itself, so it must see reset combinationally.
  assign req_ready = (state == IDLE) && !reset;

  // Next-state, burst bookkeeping and next values of the output registers.
  always_comb begin
    state_d = state;
    line_d  = line_q;
    write_d = write_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;

    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          line_d  = req_addr[ADDR_W+1:BEAT_W+2];
          write_d = req_write;
          beat_d  = '0;
          if (LATENCY > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LATENCY);
          end else begin
            state_d = req_write ? WBURST : RBURST;
          end
        end
      end
      WAIT: begin
        if (cnt_q <= CNT_W'(1)) state_d = write_q ? WBURST : RBURST;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      RBURST: begin
        if (rvalid && rready) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) state_d = IDLE;
        end
      end
      WBURST: begin
        if (wvalid && wready) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rvalid_d  = (state_d == RBURST);
    rlast_d   = rvalid_d && (beat_d == LAST_BEAT);
    rdata_d   = rvalid_d ? mem[{line_d, beat_d}] : '0;
    wready_d  = (state_d == WBURST);
    wr_done_d = (state_d == DONE);
    busy_d    = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      line_q  <= '0;
      write_q <= 1'b0;
      beat_q  <= '0;
      cnt_q   <= '0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rlast   <= 1'b0;
      wready  <= 1'b0;
      wr_done <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_d;
      line_q  <= line_d;
      write_q <= write_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      rvalid  <= rvalid_d;
      rdata   <= rdata_d;
      rlast   <= rlast_d;
      wready  <= wready_d;
      wr_done <= wr_done_d;
      busy    <= busy_d;
    end
  end

  // Backing store is never cleared. Reset forces state to IDLE, which blocks writes.
  always_ff @(posedge clk) begin
    if (wready && wvalid) mem[{line_q, beat_q}] <= wdata;
  end

endmodule

// File: tb/tb_cache_mem_responder.sv
module tb_cache_mem_responder;

  localparam int LAT   = 4;
  localparam int WORDS = 8;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_write, rvalid, rlast, rready;
  logic        wvalid, wready, wr_done, busy;
  logic [31:0] req_addr, rdata, wdata;

  logic        z_req_valid, z_req_ready, z_req_write, z_rvalid, z_rlast, z_rready;
  logic        z_wvalid, z_wready, z_wr_done, z_busy;
  logic [31:0] z_req_addr, z_rdata, z_wdata;

  cache_mem_responder #(.BLOCK_SIZE(32), .MEM_DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .rvalid(rvalid), .rdata(rdata),
    .rlast(rlast), .rready(rready), .wvalid(wvalid), .wdata(wdata),
    .wready(wready), .wr_done(wr_done), .busy(busy)
  );

  cache_mem_responder #(.BLOCK_SIZE(32), .MEM_DEPTH(DEPTH), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_write(z_req_write), .req_addr(z_req_addr), .rvalid(z_rvalid), .rdata(z_rdata),
    .rlast(z_rlast), .rready(z_rready), .wvalid(z_wvalid), .wdata(z_wdata),
    .wready(z_wready), .wr_done(z_wr_done), .busy(z_busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int wd_pulses = 0;
  bit cmp_en   = 1'b0;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (!reset && wr_done) wd_pulses++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // Transaction-level reference: word array plus progress of the current request.
  logic [31:0] ref_mem [DEPTH];
  bit          known   [DEPTH];
  bit m_busy = 0, m_write = 0, m_done = 0;
  int m_wait = 0, m_beat = 0, m_line = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_done = 0; m_wait = 0; m_beat = 0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy  = 1;
        m_write = req_write;
        m_line  = int'(((req_addr >> 2) % DEPTH) / WORDS * WORDS);
        m_beat  = 0;
        m_wait  = LAT;
      end
    end else if (m_done) begin
      m_done = 0;
      m_busy = 0;
    end else if (m_wait > 0) begin
      m_wait--;
    end else if (m_write) begin
      if (wvalid) begin
        ref_mem[m_line + m_beat] = wdata;
        known[m_line + m_beat]   = 1;
        m_beat++;
        if (m_beat == WORDS) m_done = 1;
      end
    end else if (rready) begin
      m_beat++;
      if (m_beat == WORDS) m_busy = 0;
    end
  end

  logic exp_rv, exp_wr;
  always @(negedge clk) begin
    if (cmp_en) begin
      if (reset) begin
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_req_ready", req_ready, 1'b0);
        chk1("rst_rvalid", rvalid, 1'b0);
        chk1("rst_rlast", rlast, 1'b0);
        chk1("rst_wready", wready, 1'b0);
        chk1("rst_wr_done", wr_done, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
      end else begin
        exp_rv = m_busy && !m_done && (m_wait == 0) && !m_write;
        exp_wr = m_busy && !m_done && (m_wait == 0) && m_write;
        chk1("busy", busy, m_busy);
        chk1("req_ready", req_ready, !m_busy);
        chk1("rvalid", rvalid, exp_rv);
        chk1("wready", wready, exp_wr);
        chk1("wr_done", wr_done, m_done);
        chk1("rlast", rlast, exp_rv && (m_beat == WORDS - 1));
        if (exp_rv && known[m_line + m_beat]) chk("rdata", rdata, ref_mem[m_line + m_beat]);
      end
    end
  end

  logic [31:0] rd_data [WORDS];
  logic        rd_last [WORDS];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic wr, input logic [31:0] addr, output int t0);
    int g = 0;
    req_valid = 1'b1; req_write = wr; req_addr = addr;
    while (!req_ready && g < 50) begin tick(); g++; end
    chk1("req_ready_before_handshake", req_ready, 1'b1);
    tick();
    t0 = cyc;
    req_valid = 1'b0;
  endtask

  task automatic write_line(input logic [31:0] addr, input logic [31:0] base_val,
                            input int stop_after, output int first_lat);
    int t0, beat = 0, g = 0;
    bit acc;
    first_lat = -1;
    request(1'b1, addr, t0);
    wvalid = 1'b1;
    while (beat < stop_after && g < 100) begin
      wdata = base_val + 32'(beat);
      if (wready && first_lat < 0) first_lat = cyc - t0;
      acc = wready;
      tick(); g++;
      if (acc) beat++;
    end
    wvalid = 1'b0; wdata = '0;
    chk("write_beats", beat, stop_after);
  endtask

  task automatic read_line(input logic [31:0] addr, input logic [3:0] pat,
                           input int stop_after, output int first_lat);
    int t0, n = 0, g = 0, i = 0;
    bit acc, stalled = 0;
    logic [31:0] hold_d;
    logic hold_l;
    first_lat = -1;
    request(1'b0, addr, t0);
    while (n < stop_after && g < 200) begin
      rready = pat[i % 4]; i++;
      if (rvalid && first_lat < 0) first_lat = cyc - t0;
      if (stalled) begin
        chk("stall_rdata", rdata, hold_d);
        chk1("stall_rlast", rlast, hold_l);
      end
      acc = rvalid && rready;
      if (acc) begin rd_data[n] = rdata; rd_last[n] = rlast; n++; end
      stalled = rvalid && !rready; hold_d = rdata; hold_l = rlast;
      tick(); g++;
    end
    rready = 1'b0;
    chk("read_beats", n, stop_after);
  endtask

  task automatic check_line(input string name, input logic [31:0] e [WORDS]);
    for (int i = 0; i < WORDS; i++) begin
      chk({name, "_data"}, rd_data[i], e[i]);
      chk1({name, "_rlast"}, rd_last[i], i == WORDS - 1);
    end
  endtask

  logic [31:0] exp_a [WORDS];
  logic [31:0] exp_l [WORDS];

  initial begin
    int lat, g, t0;
    req_valid = 0; req_write = 0; req_addr = '0; rready = 0; wvalid = 0; wdata = '0;
    z_req_valid = 0; z_req_write = 0; z_req_addr = '0; z_rready = 0; z_wvalid = 0; z_wdata = '0;
    for (int i = 0; i < DEPTH; i++) known[i] = 0;
    repeat (2) @(posedge clk);
    #1; cmp_en = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk1("post_reset_req_ready", req_ready, 1'b1);
    chk1("post_reset_busy", busy, 1'b0);
    tick();

    // 1: write burst, latency and completion pulse
    write_line(32'h0000_0040, 32'hA0, 8, lat);
    chk("t1_wready_latency", lat, 4);
    chk1("t1_wr_done_high", wr_done, 1'b1);
    chk1("t1_busy_in_done", busy, 1'b1);
    chk1("t1_req_ready_in_done", req_ready, 1'b0);
    tick();
    chk1("t1_wr_done_single", wr_done, 1'b0);
    chk1("t1_busy_low", busy, 1'b0);
    chk("t1_wr_done_pulses", wd_pulses, 1);

    // 2: unaligned read of the same line
    for (int i = 0; i < WORDS; i++) exp_a[i] = 32'hA0 + 32'(i);
    read_line(32'h0000_005C, 4'b1111, 8, lat);
    chk("t2_rvalid_latency", lat, 4);
    chk1("t2_req_ready_after_last", req_ready, 1'b1);
    chk1("t2_busy_after_last", busy, 1'b0);
    check_line("t2", exp_a);

    // 3: stalled read
    read_line(32'h0000_005C, 4'b1001, 8, lat);
    check_line("t3", exp_a);
    repeat (3) tick();
    chk1("t3_no_extra_beat", rvalid, 1'b0);

    // 4: modulo wrap-around of the byte address
    write_line(32'h0000_1020, 32'hB0, 8, lat);
    tick();
    read_line(32'h0000_0020, 4'b1111, 8, lat);
    for (int i = 0; i < WORDS; i++) exp_l[i] = 32'hB0 + 32'(i);
    check_line("t4", exp_l);

    // 5a: reset mid-read, then a fresh full read
    read_line(32'h0000_0040, 4'b1111, 3, lat);
    reset = 1'b1;
    #1;
    chk1("t5_rvalid_in_reset", rvalid, 1'b0);
    chk("t5_rdata_in_reset", rdata, 32'h0);
    chk1("t5_req_ready_in_reset", req_ready, 1'b0);
    tick(); tick();
    reset = 1'b0;
    tick();
    read_line(32'h0000_0040, 4'b1111, 8, lat);
    check_line("t5_fresh", exp_a);

    // 5b: reset after three write beats
    write_line(32'h0000_0040, 32'hC0, 3, lat);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    chk("t5_no_wr_done", wd_pulses, 2);
    read_line(32'h0000_0040, 4'b1111, 8, lat);
    exp_l[0] = 32'hC0; exp_l[1] = 32'hC1; exp_l[2] = 32'hC2;
    for (int i = 3; i < WORDS; i++) exp_l[i] = 32'hA0 + 32'(i);
    check_line("t5_partial", exp_l);

    // 6: zero-latency instance
    z_req_valid = 1; z_req_write = 1; z_req_addr = 32'h40;
    g = 0;
    while (!z_req_ready && g < 20) begin tick(); g++; end
    tick();
    z_req_valid = 0;
    chk1("t6_wready_immediate", z_wready, 1'b1);
    z_wvalid = 1;
    for (int i = 0; i < WORDS; i++) begin
      z_wdata = 32'h50 + 32'(i);
      chk1("t6_wready_beat", z_wready, 1'b1);
      tick();
    end
    z_wvalid = 0;
    chk1("t6_wr_done", z_wr_done, 1'b1);
    tick();
    for (int pass = 0; pass < 2; pass++) begin
      z_req_valid = 1; z_req_write = 0; z_req_addr = 32'h40;
      g = 0;
      while (!z_req_ready && g < 20) begin tick(); g++; end
      tick();
      z_req_valid = 0;
      chk1("t6_rvalid_immediate", z_rvalid, 1'b1);
      z_rready = 1;
      for (int i = 0; i < WORDS; i++) begin
        chk("t6_rdata", z_rdata, 32'h50 + 32'(i));
        chk1("t6_rlast", z_rlast, i == WORDS - 1);
        tick();
      end
      z_rready = 0;
      chk1("t6_idle_after_read", z_req_ready, 1'b1);
      if (pass == 0) begin
        z_wvalid = 1; z_wdata = 32'hDEAD_BEEF; z_rready = 1;
        for (int i = 0; i < 3; i++) begin
          tick();
          chk1("t6_idle_busy", z_busy, 1'b0);
          chk1("t6_idle_rvalid", z_rvalid, 1'b0);
          chk1("t6_idle_wready", z_wready, 1'b0);
        end
        z_wvalid = 0; z_rready = 0;
      end
    end

    t0 = 0;
    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
